// File: rtl/ingredient_column_ctrl.sv
//------------------------------------------------------------------------------
// Module      : ingredient_column_ctrl
// Description : Drop sequencer for one plate column of stacked ingredient
//               pieces. It allows one piece to fall at a time, hands the drop
//               on to the next piece when the falling piece reaches it, aborts
//               a drop that runs too long, and reports landing scores and
//               column completion.
//               Optional macro CASCADE_BONUS_EN: when defined, each landing
//               scores BASE_SCORE << cascade level, saturating at 255.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ingredient_column_ctrl #(
    parameter int N_ING        = 4,
    parameter int CONTACT_DY   = 8,
    parameter int DROP_TIMEOUT = 255,
    parameter int BASE_SCORE   = 50
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic [N_ING-1:0]     step_req,
    input  logic [N_ING-1:0]     ing_finish,
    input  logic [10*N_ING-1:0]  ing_y,
    output logic [N_ING-1:0]     fall,
    output logic [2:0]           active_idx,
    output logic                 busy,
    output logic                 score_pulse,
    output logic [7:0]           score_value,
    output logic                 column_done
);

    localparam int         TW       = (DROP_TIMEOUT < 2) ? 1 : $clog2(DROP_TIMEOUT + 1);
    localparam logic [7:0] BASE_SAT = (BASE_SCORE > 255) ? 8'd255 : 8'(BASE_SCORE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DROP  = 3'd1,
        S_KNOCK = 3'd2,
        S_LAND  = 3'd3,
        S_ABORT = 3'd4,
        S_CHECK = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       active_q, active_d;
    logic [2:0]       knock_q, knock_d;
    logic [2:0]       casc_q, casc_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [N_ING-1:0] pending_q, pending_d;
    logic             done_q, done_d;
    logic [N_ING-1:0] fall_q, fall_d;
    logic             busy_q, busy_d;
    logic             pulse_q, pulse_d;
    logic [7:0]       score_q, score_d;

    logic [7:0]       fin_ext;
    logic [79:0]      y_ext;
    logic [9:0]       y_arr [8];
    logic             grant_vld;
    logic [2:0]       grant_idx;
    logic             below_vld;
    logic [2:0]       below_idx;
    logic [9:0]       y_act;
    logic [9:0]       y_below;
    logic             contact;
    logic [N_ING-1:0] clr_mask;
    logic [7:0]       score_next;

    // Widen per-piece inputs to the full 8-piece range so a 3-bit index is always in bounds
    always_comb begin
        fin_ext = 8'(ing_finish);
        y_ext   = 80'(ing_y);
        for (int i = 0; i < 8; i++) begin
            y_arr[i] = y_ext[10*i +: 10];
        end
    end

    // Topmost pending piece wins the grant
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 3'd0;
        for (int i = N_ING - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                grant_vld = 1'b1;
                grant_idx = 3'(i);
            end
        end
    end

    // Nearest unfinished piece below the falling one, and whether it has been reached
    always_comb begin
        below_vld = 1'b0;
        below_idx = 3'd0;
        for (int j = N_ING - 1; j >= 0; j--) begin
            if ((3'(j) > active_q) && !ing_finish[j]) begin
                below_vld = 1'b1;
                below_idx = 3'(j);
            end
        end
        y_act   = y_arr[active_q];
        y_below = y_arr[below_idx];
        contact = below_vld && (y_below >= y_act) && ((y_below - y_act) <= 10'(CONTACT_DY));
    end

    // Points for the piece that is stopping now, using the current cascade depth
`ifdef CASCADE_BONUS_EN
    logic [15:0] bonus_wide;
    always_comb begin
        bonus_wide = 16'(BASE_SAT) << casc_q;
        score_next = (bonus_wide > 16'd255) ? 8'd255 : bonus_wide[7:0];
    end
`else
    always_comb begin
        score_next = BASE_SAT;
    end
`endif

    // Next-state logic, pending bookkeeping and registered-output precomputation
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        knock_d  = knock_q;
        casc_d   = casc_q;
        timer_d  = timer_q;
        clr_mask = '0;

        case (state_q)
            S_IDLE: begin
                if (!done_q && grant_vld) begin
                    active_d = grant_idx;
                    clr_mask = N_ING'(8'd1 << grant_idx);
                    casc_d   = 3'd0;
                    timer_d  = '0;
                    state_d  = S_DROP;
                end
            end
            S_DROP: begin
                timer_d = timer_q + 1'b1;
                if (fin_ext[active_q]) begin
                    state_d = S_LAND;
                end else if (contact) begin
                    knock_d = below_idx;
                    state_d = S_KNOCK;
                end else if (timer_q == TW'(DROP_TIMEOUT)) begin
                    state_d = S_ABORT;
                end
            end
            S_KNOCK: begin
                active_d = knock_q;
                clr_mask = N_ING'(8'd1 << knock_q);
                casc_d   = (casc_q == 3'd7) ? 3'd7 : casc_q + 3'd1;
                timer_d  = '0;
                state_d  = S_DROP;
            end
            S_LAND:  state_d = S_CHECK;
            S_ABORT: state_d = S_CHECK;
            S_CHECK: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // New requests are accepted for unfinished pieces until the column is done
        pending_d = (pending_q | (done_q ? '0 : (step_req & ~ing_finish))) & ~clr_mask;
        done_d    = done_q | ((state_q == S_CHECK) && (&ing_finish));

        fall_d  = (state_d == S_DROP) ? N_ING'(8'd1 << active_d) : '0;
        busy_d  = (state_d != S_IDLE);
        pulse_d = (state_d == S_KNOCK) || (state_d == S_LAND);
        score_d = pulse_d ? score_next : score_q;
    end

    // State and output registers; reset takes effect immediately, even mid-drop
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            active_q  <= 3'd0;
            knock_q   <= 3'd0;
            casc_q    <= 3'd0;
            timer_q   <= '0;
            pending_q <= '0;
            done_q    <= 1'b0;
            fall_q    <= '0;
            busy_q    <= 1'b0;
            pulse_q   <= 1'b0;
            score_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            knock_q   <= knock_d;
            casc_q    <= casc_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            fall_q    <= fall_d;
            busy_q    <= busy_d;
            pulse_q   <= pulse_d;
            score_q   <= score_d;
        end
    end

    assign fall        = fall_q;
    assign active_idx  = active_q;
    assign busy        = busy_q;
    assign score_pulse = pulse_q;
    assign score_value = score_q;
    assign column_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_ingredient_column_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_ingredient_column_ctrl
// Description : Directed self-checking bench for ingredient_column_ctrl.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ingredient_column_ctrl;

    logic        frame_clk = 1'b0;
    logic        Reset     = 1'b1;

    // Main instance (default parameters)
    logic [3:0]  step_req   = '0;
    logic [3:0]  ing_finish = '0;
    logic [39:0] ing_y      = '0;
    logic [3:0]  fall;
    logic [2:0]  active_idx;
    logic        busy;
    logic        score_pulse;
    logic [7:0]  score_value;
    logic        column_done;

    // Short-timeout instance
    logic [3:0]  to_step   = '0;
    logic [3:0]  to_fin    = '0;
    logic [39:0] to_y      = {10'd400, 10'd300, 10'd200, 10'd100};
    logic [3:0]  to_fall;
    logic [2:0]  to_active;
    logic        to_busy;
    logic        to_pulse;
    logic [7:0]  to_score;
    logic        to_done;

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_cnt = 0;
    int to_pulse_cnt = 0;

    ingredient_column_ctrl u_dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .step_req    (step_req),
        .ing_finish  (ing_finish),
        .ing_y       (ing_y),
        .fall        (fall),
        .active_idx  (active_idx),
        .busy        (busy),
        .score_pulse (score_pulse),
        .score_value (score_value),
        .column_done (column_done)
    );

    ingredient_column_ctrl #(.DROP_TIMEOUT(10)) u_dut_to (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .step_req    (to_step),
        .ing_finish  (to_fin),
        .ing_y       (to_y),
        .fall        (to_fall),
        .active_idx  (to_active),
        .busy        (to_busy),
        .score_pulse (to_pulse),
        .score_value (to_score),
        .column_done (to_done)
    );

    always #5 frame_clk = ~frame_clk;

    // Count landing pulses on the falling edge, away from the active edge
    always @(negedge frame_clk) begin
        if (score_pulse) pulse_cnt++;
        if (to_pulse)    to_pulse_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset();
        step_req   = '0;
        ing_finish = '0;
        ing_y      = {10'd200, 10'd150, 10'd100, 10'd40};
        Reset      = 1'b1;
        tick();
        Reset      = 1'b0;
    endtask

    task automatic pulse_step(input logic [3:0] req);
        step_req = req;
        tick();
        step_req = '0;
    endtask

    int base;
    int cnt;
    logic [7:0] exp_bonus;

    initial begin
`ifdef CASCADE_BONUS_EN
        exp_bonus = 8'd100;
`else
        exp_bonus = 8'd50;
`endif
        // ---------------- Reset state ----------------
        do_reset();
        repeat (3) tick();
        check("rst_fall",   fall, 0);
        check("rst_busy",   busy, 0);
        check("rst_done",   column_done, 0);
        check("rst_active", active_idx, 0);
        check("rst_score",  score_value, 0);
        check("rst_pulses", pulse_cnt, 0);

        // ---------------- Single drop and landing ----------------
        base = pulse_cnt;
        pulse_step(4'b0001);
        check("s1_fall_pre", fall, 0);
        tick();
        check("s1_fall",  fall, 4'b0001);
        check("s1_busy",  busy, 1);
        repeat (19) tick();
        check("s1_fall_hold", fall, 4'b0001);
        ing_finish = 4'b0001;
        tick();
        check("s1_land_pulse", score_pulse, 1);
        check("s1_land_value", score_value, 50);
        check("s1_land_fall",  fall, 0);
        tick();
        check("s1_check_busy",  busy, 1);
        check("s1_check_pulse", score_pulse, 0);
        tick();
        check("s1_idle_busy", busy, 0);
        check("s1_done",      column_done, 0);
        check("s1_pulses",    pulse_cnt - base, 1);

        // ---------------- Knock-down cascade ----------------
        do_reset();
        base = pulse_cnt;
        pulse_step(4'b0001);
        tick();
        check("c_fall0", fall, 4'b0001);
        ing_y[9:0] = 10'd96;
        tick();
        check("c_knock_fall",  fall, 0);
        check("c_knock_pulse", score_pulse, 1);
        check("c_knock_value", score_value, 50);
        check("c_knock_busy",  busy, 1);
        tick();
        check("c_fall1",   fall, 4'b0010);
        check("c_active1", active_idx, 1);
        check("c_pulse_off", score_pulse, 0);
        ing_finish = 4'b0010;
        tick();
        check("c_land_pulse", score_pulse, 1);
        check("c_land_value", score_value, exp_bonus);
        repeat (2) tick();
        check("c_idle_busy", busy, 0);
        check("c_pulses", pulse_cnt - base, 2);

        // ---------------- Simultaneous requests ----------------
        do_reset();
        pulse_step(4'b1010);
        tick();
        check("p_fall1",   fall, 4'b0010);
        check("p_active1", active_idx, 1);
        ing_finish = 4'b0010;
        tick();
        check("p_land1", score_pulse, 1);
        tick();
        tick();
        check("p_idle_busy", busy, 0);
        tick();
        check("p_fall3",   fall, 4'b1000);
        check("p_active3", active_idx, 3);
        ing_finish = 4'b1010;
        tick();
        check("p_land3", score_pulse, 1);
        repeat (2) tick();
        check("p_done", column_done, 0);

        // ---------------- Watchdog timeout (DROP_TIMEOUT = 10) ----------------
        do_reset();
        base = to_pulse_cnt;
        to_step = 4'b0001;
        tick();
        to_step = '0;
        tick();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (to_fall != 4'b0001) break;
            cnt++;
            tick();
        end
        check("t_fall_frames", cnt, 11);
        check("t_abort_fall",  to_fall, 0);
        check("t_abort_busy",  to_busy, 1);
        check("t_abort_pulse", to_pulse, 0);
        repeat (2) tick();
        check("t_idle_busy", to_busy, 0);
        tick();
        check("t_no_regrant", to_fall, 0);
        check("t_pulses", to_pulse_cnt - base, 0);

        // ---------------- Column completion ----------------
        do_reset();
        pulse_step(4'b0001);
        tick();
        check("d_fall0", fall, 4'b0001);
        ing_finish = 4'b1111;
        tick();
        check("d_land", score_pulse, 1);
        tick();
        check("d_done_pre", column_done, 0);
        tick();
        check("d_done", column_done, 1);
        ing_finish = 4'b0000;
        pulse_step(4'b0001);
        repeat (3) tick();
        check("d_ignored_fall", fall, 0);
        check("d_ignored_busy", busy, 0);
        check("d_sticky", column_done, 1);

        // ---------------- Asynchronous reset mid-drop ----------------
        do_reset();
        pulse_step(4'b0001);
        tick();
        check("r_fall", fall, 4'b0001);
        #2;
        Reset = 1'b1;
        #1;
        check("r_async_fall", fall, 0);
        check("r_async_busy", busy, 0);
        tick();
        Reset = 1'b0;
        tick();
        check("r_after_fall", fall, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ingredient_column_ctrl.md
Name: ingredient_column_ctrl

Overview:
Sequences the falling ingredients of one plate column, up to N_ING stacked pieces. Index 0 is the topmost piece and N_ING-1 the bottommost. The block sits between the chef/collision logic and the per-piece ingredient movers. It arbitrates which piece may fall (exactly one at a time per column), propagates knock-down cascades, and emits score events plus a column-complete flag to the game FSM.

Parameters:
N_ING, 4, number of ingredient pieces in the column (2..8)
CONTACT_DY, 8, vertical distance (screen px) at or below which a falling piece knocks the next piece
DROP_TIMEOUT, 255, max frames a single drop may last before watchdog abort
BASE_SCORE, 50, points per landed piece

Ports:
frame_clk  in  1  frame-rate clock
Reset  in  1  asynchronous, active-high reset
step_req  in  N_ING  pulse: chef fully walked over piece i
ing_finish  in  N_ING  level: piece i has reached its plate
ing_y  in  10*N_ING  screen Y of piece i, bits [10i+9:10i]
fall  out  N_ING  one-hot or zero; drives fall input of piece i
active_idx  out  3  index of piece currently driven (valid when busy)
busy  out  1  a drop or cascade is in progress
score_pulse  out  1  one-frame pulse when a piece lands
score_value  out  8  points for this landing; valid with score_pulse
column_done  out  1  all N_ING pieces finished

Behaviour:
- Reset: fall=0, active_idx=0, busy=0, score_pulse=0, score_value=0, column_done=0, pending=0, cascade_lvl=0, timer=0; FSM→IDLE.
- pending[N_ING] bitmap: bit i set by step_req[i] when ing_finish[i]=0, on any cycle in any state. Bit is cleared when piece i is granted. step_req for a finished piece is ignored.
- States:
  IDLE: if pending≠0, grant lowest set index k (topmost first). active_idx←k, clear pending[k], cascade_lvl←0, timer←0 → DROP. busy=0 while in IDLE.
  DROP: fall[active_idx]=1, all other fall bits 0. timer increments each frame.
    - If ing_finish[active_idx]=1 → LAND.
    - Otherwise, find the nearest j>active_idx with ing_finish[j]=0. If ing_y[j]−ing_y[active_idx] ≤ CONTACT_DY (unsigned, computed only when ing_y[j]≥ing_y[active_idx]) → KNOCK.
    - Otherwise, if timer=DROP_TIMEOUT → ABORT.
    - Priority when several conditions hold: finish > contact > timeout.
  KNOCK (1 frame): score_pulse=1 for the stopped piece. active_idx←j, cascade_lvl←cascade_lvl+1 (saturating at 7), timer←0, pending[j] cleared → DROP. fall is 0 during KNOCK; the handover creates a 1-frame gap.
  LAND (1 frame): score_pulse=1, fall=0 → CHECK.
  ABORT (1 frame): fall=0, no score → CHECK.
  CHECK: column_done←&ing_finish → IDLE.
- score_value: BASE_SCORE in the base build; see optional feature. Width 8 bits, saturating at 255.
- busy=1 in DROP, KNOCK, LAND, ABORT, CHECK.
- column_done is sticky until Reset. Once set, step_req is ignored and the FSM stays in IDLE.
- All outputs are registered: fall asserts the frame after the grant decision.
- Reset mid-drop: immediate return to reset values. fall drops asynchronously.

Optional Feature:
CASCADE_BONUS_EN
- Defined: score_value = BASE_SCORE << cascade_lvl, saturating at 255. The first piece scores BASE, the first knocked piece 2×BASE, and so on.
- Undefined: score_value = BASE_SCORE always; cascade_lvl is still tracked internally.

Test Plan:
- Reset with step_req=0: after 3 frames fall=0, busy=0, column_done=0, score_pulse never seen.
- step_req=0001, ing_y={200,150,100,40}, ing_finish[0] raised 20 frames later: fall=0001 from frame 1; score_pulse with value 50 one frame after finish; busy=0 after CHECK.
- Cascade: piece0 falls, ing_y0 moves to 96 with ing_y1=100: KNOCK, score 50, then fall=0010. Piece1 finishes: score 50, or 100 with CASCADE_BONUS_EN.
- Simultaneous step_req=1010 in one frame: piece1 granted first, piece3 remains pending and is granted after piece1 completes.
- Timeout with DROP_TIMEOUT=10, finish never raised: fall deasserted at frame 11, no score_pulse, FSM returns to IDLE.
- All ing_finish=1111 after the final landing: column_done=1 stays high, a later step_req=0001 produces no fall; Reset mid-DROP clears fall immediately.
